// File: rtl/display_scan_mux_if.sv
// display_scan_mux_if
//   Bundles the load side and the decoder/anode side of display_scan_mux.
//   Signals:
//     load        : single-cycle strobe; captures value into the pending buffer
//     value       : 4*N_DIGITS-bit hex value; nibble i feeds digit i
//     digit_nib   : nibble for the digit currently enabled
//     blank       : 1 = the currently enabled digit must be dark
//     digit_en    : one-hot active-low digit enables
//     upd_pending : a loaded value is waiting for the next frame boundary
//     frame_done  : one-cycle pulse after the last digit slot of a frame ends
//   Modports:
//     master : producer of load/value, consumer of the display outputs
//     slave  : the scan multiplexer itself
interface display_scan_mux_if #(
  parameter int N_DIGITS = 4
);
  logic                  load;
  logic [4*N_DIGITS-1:0] value;
  logic [3:0]            digit_nib;
  logic                  blank;
  logic [N_DIGITS-1:0]   digit_en;
  logic                  upd_pending;
  logic                  frame_done;

  modport master (
    output load, value,
    input  digit_nib, blank, digit_en, upd_pending, frame_done
  );

  modport slave (
    input  load, value,
    output digit_nib, blank, digit_en, upd_pending, frame_done
  );
endinterface

// File: rtl/display_scan_mux.sv
// display_scan_mux
//   Holds a multi-digit hex value and time-multiplexes one nibble at a time
//   onto a 7-segment decoder, with the matching active-low digit enable and
//   optional leading-zero blanking. Loaded values are double-buffered and only
//   become visible at a frame boundary, so a frame never mixes old and new
//   digits.
//   Ports:
//     clk     : system clock, rising edge
//     reset_n : asynchronous active-low reset
//     bus     : display_scan_mux_if.slave (load/value in, display outputs out)
//   Handshake: load is a fire-and-forget strobe with no ready/backpressure.
//   Every cycle with load=1 is a transfer of value; the last transfer before a
//   frame boundary wins, and a transfer on the boundary cycle itself goes
//   straight into the active buffer.
module display_scan_mux #(
  parameter int N_DIGITS = 4,
  parameter int TICK_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  display_scan_mux_if.slave  bus
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int VW = 4 * N_DIGITS;

  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

  logic [CW-1:0]       count_q;
  logic [IW-1:0]       idx_q;
  logic [IW-1:0]       idx_nxt;
  logic [VW-1:0]       active_q;
  logic [VW-1:0]       active_nxt;
  logic [VW-1:0]       pending_q;
  logic                pending_valid_q;
  logic                pending_valid_nxt;
  logic                tick;
  logic                wrap;
  logic [3:0]          nib_nxt;
  logic                blank_nxt;
  logic                upper_nz;
  logic [N_DIGITS-1:0] en_nxt;

  always_comb begin
    tick = (count_q == CNT_LAST);
    wrap = tick && (idx_q == IDX_LAST);
  end

  // Next slot index and buffer state.
  always_comb begin
    idx_nxt           = idx_q;
    active_nxt        = active_q;
    pending_valid_nxt = pending_valid_q;
    if (tick) begin
      idx_nxt = wrap ? '0 : idx_q + IW'(1);
    end
    if (wrap) begin
      // A load landing on the boundary bypasses the pending buffer.
      if (bus.load) begin
        active_nxt = bus.value;
      end else if (pending_valid_q) begin
        active_nxt = pending_q;
      end
      pending_valid_nxt = 1'b0;
    end else if (bus.load) begin
      pending_valid_nxt = 1'b1;
    end
  end

  // Display outputs are computed from the post-edge index and active value so
  // nibble, enable and blank all change together.
  always_comb begin
    nib_nxt          = active_nxt[{idx_nxt, 2'b00} +: 4];
    en_nxt           = '1;
    en_nxt[idx_nxt]  = 1'b0;
    upper_nz         = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if ((i >= int'(idx_nxt)) && (active_nxt[4*i +: 4] != 4'h0)) begin
        upper_nz = 1'b1;
      end
    end
    // Digit 0 is never blanked so a zero value still shows a single "0".
    blank_nxt = BLANK_LZ && (idx_nxt != '0) && !upper_nz;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q         <= '0;
      idx_q           <= '0;
      active_q        <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      bus.digit_nib   <= 4'h0;
      bus.blank       <= 1'b0;
      bus.digit_en    <= ~N_DIGITS'(1);
      bus.upd_pending <= 1'b0;
      bus.frame_done  <= 1'b0;
    end else begin
      count_q         <= tick ? '0 : count_q + CW'(1);
      idx_q           <= idx_nxt;
      active_q        <= active_nxt;
      if (bus.load) begin
        pending_q <= bus.value;
      end
      pending_valid_q <= pending_valid_nxt;
      bus.digit_nib   <= nib_nxt;
      bus.blank       <= blank_nxt;
      bus.digit_en    <= en_nxt;
      bus.upd_pending <= pending_valid_nxt;
      bus.frame_done  <= wrap;
    end
  end

endmodule

// File: tb/tb_display_scan_mux.sv
module tb_display_scan_mux;

  localparam int N = 4;
  localparam int T = 4;
  localparam int FRAME = N * T;

  logic clk;
  logic reset_n;

  display_scan_mux_if #(.N_DIGITS(N)) bus ();
  display_scan_mux_if #(.N_DIGITS(N)) bus_nb ();

  display_scan_mux #(.N_DIGITS(N), .TICK_DIV(T), .BLANK_LZ(1'b1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  display_scan_mux #(.N_DIGITS(N), .TICK_DIV(T), .BLANK_LZ(1'b0)) dut_nb (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_nb.slave)
  );

  int tests  = 0;
  int failed = 0;

  logic [3:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Edge count since reset release gives slot and digit index by division;
  // buffers follow the load/boundary rules.
  int unsigned m_e;
  logic [15:0] m_active;
  logic [15:0] m_pend;
  bit          m_pv;
  bit          m_fd;

  always @(posedge clk or negedge reset_n) begin : model
    bit w;
    if (!reset_n) begin
      m_e      = 0;
      m_active = 16'h0;
      m_pend   = 16'h0;
      m_pv     = 1'b0;
      m_fd     = 1'b0;
    end else begin
      w = ((m_e % FRAME) == FRAME - 1);
      if (w) begin
        if (bus.load)   m_active = bus.value;
        else if (m_pv)  m_active = m_pend;
        m_pv = 1'b0;
      end else if (bus.load) begin
        m_pend = bus.value;
        m_pv   = 1'b1;
      end
      m_fd = w;
      m_e++;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin : compare
    int          idx;
    logic [15:0] upper;
    logic [3:0]  e_nib;
    logic        e_blank;
    logic [3:0]  e_en;
    idx     = (m_e / T) % N;
    upper   = m_active >> (4 * idx);
    e_nib   = upper[3:0];
    e_blank = (idx != 0) && (upper == 16'h0);
    e_en    = ~(4'b0001 << idx);
    check("nib",        32'(bus.digit_nib),   32'(e_nib));
    check("blank",      32'(bus.blank),       32'(e_blank));
    check("en",         32'(bus.digit_en),    32'(e_en));
    check("upd",        32'(bus.upd_pending), 32'(m_pv));
    check("frame_done", 32'(bus.frame_done),  32'(m_fd));
    check("nb_nib",     32'(bus_nb.digit_nib), 32'(e_nib));
    check("nb_blank",   32'(bus_nb.blank),     32'h0);
    check("nb_en",      32'(bus_nb.digit_en),  32'(e_en));
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_val(input logic [15:0] v);
    bus.load     = 1'b1;
    bus.value    = v;
    bus_nb.load  = 1'b1;
    bus_nb.value = v;
    @(negedge clk);
    bus.load    = 1'b0;
    bus_nb.load = 1'b0;
  endtask

  task automatic lit(input string name, input logic [3:0] nib, input logic blank,
                     input logic [3:0] en, input logic upd, input logic fd);
    check({name, "_nib"},   32'(bus.digit_nib),   32'(nib));
    check({name, "_blank"}, 32'(bus.blank),       32'(blank));
    check({name, "_en"},    32'(bus.digit_en),    32'(en));
    check({name, "_upd"},   32'(bus.upd_pending), 32'(upd));
    check({name, "_fd"},    32'(bus.frame_done),  32'(fd));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n      = 1'b0;
    bus.load     = 1'b0;
    bus.value    = 16'h0;
    bus_nb.load  = 1'b0;
    bus_nb.value = 16'h0;
    exp_q        = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h4};

    cycles(2);
    lit("rst0", 4'h0, 1'b0, 4'b1110, 1'b0, 1'b0);
    reset_n = 1'b1;

    // Basic scan: 1234 becomes visible at the first wrap (edge 16).
    load_val(16'h1234);
    check("pend_after_load", 32'(bus.upd_pending), 32'h1);
    cycles(15);
    lit("scan_s0", exp_q.pop_front(), 1'b0, 4'b1110, 1'b0, 1'b1);
    cycles(4);
    lit("scan_s1", exp_q.pop_front(), 1'b0, 4'b1101, 1'b0, 1'b0);
    cycles(4);
    lit("scan_s2", exp_q.pop_front(), 1'b0, 4'b1011, 1'b0, 1'b0);
    cycles(4);
    lit("scan_s3", exp_q.pop_front(), 1'b0, 4'b0111, 1'b0, 1'b0);
    cycles(4);
    lit("scan_f2", exp_q.pop_front(), 1'b0, 4'b1110, 1'b0, 1'b1);

    // Mid-frame load at idx 2 (edge 41).
    cycles(8);
    load_val(16'hABCD);
    lit("mid_s2", 4'h2, 1'b0, 4'b1011, 1'b1, 1'b0);
    cycles(3);
    lit("mid_s3", 4'h1, 1'b0, 4'b0111, 1'b1, 1'b0);
    cycles(4);
    lit("mid_new0", 4'hD, 1'b0, 4'b1110, 1'b0, 1'b1);
    cycles(4);
    lit("mid_new1", 4'hC, 1'b0, 4'b1101, 1'b0, 1'b0);

    // Collision: pending 1111, then 00F0 loaded on the wrap edge (edge 64).
    load_val(16'h1111);
    check("col_pend", 32'(bus.upd_pending), 32'h1);
    cycles(10);
    load_val(16'h00F0);
    lit("col_s0", 4'h0, 1'b0, 4'b1110, 1'b0, 1'b1);
    cycles(4);
    lit("col_s1", 4'hF, 1'b0, 4'b1101, 1'b0, 1'b0);
    cycles(4);
    lit("col_s2", 4'h0, 1'b1, 4'b1011, 1'b0, 1'b0);
    cycles(4);
    lit("col_s3", 4'h0, 1'b1, 4'b0111, 1'b0, 1'b0);
    cycles(4);

    // Leading-zero blanking with 0050 (visible from edge 96).
    load_val(16'h0050);
    cycles(15);
    lit("lz50_s0", 4'h0, 1'b0, 4'b1110, 1'b0, 1'b1);
    cycles(4);
    lit("lz50_s1", 4'h5, 1'b0, 4'b1101, 1'b0, 1'b0);
    cycles(4);
    lit("lz50_s2", 4'h0, 1'b1, 4'b1011, 1'b0, 1'b0);
    check("lz50_nb_blank", 32'(bus_nb.blank), 32'h0);
    cycles(4);
    lit("lz50_s3", 4'h0, 1'b1, 4'b0111, 1'b0, 1'b0);

    // Value 0: only digit 0 lit (visible from edge 112).
    load_val(16'h0000);
    cycles(3);
    lit("lz0_s0", 4'h0, 1'b0, 4'b1110, 1'b0, 1'b1);
    cycles(4);
    lit("lz0_s1", 4'h0, 1'b1, 4'b1101, 1'b0, 1'b0);
    check("lz0_nb_blank", 32'(bus_nb.blank), 32'h0);

    // Reset mid-frame at idx 3 with a pending value.
    load_val(16'h1234);
    cycles(7);
    lit("prerst", 4'h0, 1'b1, 4'b0111, 1'b1, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    lit("rst_async", 4'h0, 1'b0, 4'b1110, 1'b0, 1'b0);
    @(negedge clk);
    cycles(2);
    reset_n = 1'b1;
    cycles(3);
    lit("rst_hold", 4'h0, 1'b0, 4'b1110, 1'b0, 1'b0);
    cycles(1);
    lit("rst_tick", 4'h0, 1'b1, 4'b1101, 1'b0, 1'b0);
    cycles(FRAME);

    #1;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
